// File: rtl/hms_alarm_core.sv
// hms_alarm_core: hours/minutes/seconds clock with N_ALARM alarm channels, a three-mode
// user interface (CLOCK / SETUP / ALARM) and a ringing controller.
//
// Optional feature: define SNOOZE_EN to build the snooze logic. Without it, i_snooze is
// accepted but ignored and no snooze state exists.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_mode           advance mode CLOCK -> SETUP -> ALARM -> CLOCK (resets edit field)
//   i_pos            advance edit field SEC -> MIN -> HOUR (SETUP / ALARM only)
//   i_inc            increment selected field of time (SETUP) or alarm[o_sel] (ALARM)
//   i_sel            advance selected alarm (ALARM only)
//   i_tgl            toggle enable of selected alarm (any mode)
//   i_stop           stop ring / cancel pending snooze
//   i_snooze         snooze an active ring (SNOOZE_EN builds only)
//   o_hour/min/sec   displayed time, or alarm[o_sel] in ALARM mode
//   o_mode, o_pos    current mode and edit field
//   o_sel            selected alarm index
//   o_alarm_en       per-channel alarm enables
//   o_ring, o_ring_id  ring active and the channel that triggered it
//   o_tick           one-cycle one-second strobe
module hms_alarm_core #(
    parameter int unsigned CLK_DIV    = 50000000,
    parameter int unsigned N_ALARM    = 2,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_mode,
    input  logic               i_pos,
    input  logic               i_inc,
    input  logic               i_sel,
    input  logic               i_tgl,
    input  logic               i_stop,
    input  logic               i_snooze,
    output logic [4:0]         o_hour,
    output logic [5:0]         o_min,
    output logic [5:0]         o_sec,
    output logic [1:0]         o_mode,
    output logic [1:0]         o_pos,
    output logic [1:0]         o_sel,
    output logic [N_ALARM-1:0] o_alarm_en,
    output logic               o_ring,
    output logic [1:0]         o_ring_id,
    output logic               o_tick
);

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_SETUP = 2'd1;
    localparam logic [1:0] MODE_ALARM = 2'd2;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    localparam logic [31:0] TICK_MAX = 32'(CLK_DIV - 1);
    localparam logic [1:0]  SEL_MAX  = 2'(N_ALARM - 1);
    localparam logic [7:0]  RING_MAX = 8'(RING_SEC - 1);

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    logic [31:0]        cnt_q, cnt_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d, sec_q, sec_d;
    logic [1:0]         mode_q, mode_d, pos_q, pos_d, sel_q, sel_d;
    logic [N_ALARM-1:0] en_q, en_d;
    logic [4:0]         alm_h_q [N_ALARM];
    logic [4:0]         alm_h_d [N_ALARM];
    logic [5:0]         alm_m_q [N_ALARM];
    logic [5:0]         alm_m_d [N_ALARM];
    logic [5:0]         alm_s_q [N_ALARM];
    logic [5:0]         alm_s_d [N_ALARM];
    logic               ring_q, ring_d;
    logic [1:0]         ring_id_q, ring_id_d;
    logic [7:0]         ring_cnt_q, ring_cnt_d;

    logic               tick, edit_ok, hit, ring_chan_en, ring_kill;
    logic [1:0]         hit_id;

`ifdef SNOOZE_EN
    localparam logic [15:0] SNZ_MAX = 16'(SNOOZE_SEC - 1);
    logic               snz_q, snz_d;
    logic [15:0]        snz_cnt_q, snz_cnt_d;
`else
    logic               unused_snooze;
    assign unused_snooze = i_snooze;
`endif

    // Counter is frozen in SETUP, so leaving SETUP always restarts a full second.
    assign tick    = (mode_q != MODE_SETUP) && (cnt_q == TICK_MAX);
    // A mode change swallows same-cycle edit pulses.
    assign edit_ok = !i_mode;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (mode_q == MODE_SETUP || tick) cnt_d = '0;

        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (tick) begin
            sec_d = inc60(sec_q);
            if (sec_q == 6'd59) begin
                min_d = inc60(min_q);
                if (min_q == 6'd59) hour_d = inc24(hour_q);
            end
        end else if (mode_q == MODE_SETUP && i_inc && edit_ok) begin
            case (pos_q)
                POS_SEC:  sec_d  = inc60(sec_q);
                POS_MIN:  min_d  = inc60(min_q);
                default:  hour_d = inc24(hour_q);
            endcase
        end

        mode_d = mode_q;
        pos_d  = pos_q;
        sel_d  = sel_q;
        if (i_mode) begin
            case (mode_q)
                MODE_CLOCK: mode_d = MODE_SETUP;
                MODE_SETUP: mode_d = MODE_ALARM;
                default:    mode_d = MODE_CLOCK;
            endcase
            pos_d = POS_SEC;
        end else begin
            if (i_pos && mode_q != MODE_CLOCK) pos_d = (pos_q == POS_HOUR) ? POS_SEC : pos_q + 2'd1;
            if (i_sel && mode_q == MODE_ALARM) sel_d = (sel_q == SEL_MAX) ? 2'd0 : sel_q + 2'd1;
        end

        en_d    = en_q;
        alm_h_d = alm_h_q;
        alm_m_d = alm_m_q;
        alm_s_d = alm_s_q;
        for (int i = 0; i < int'(N_ALARM); i++) begin
            if (2'(i) == sel_q) begin
                if (i_tgl) en_d[i] = ~en_q[i];
                if (mode_q == MODE_ALARM && i_inc && edit_ok) begin
                    case (pos_q)
                        POS_SEC:  alm_s_d[i] = inc60(alm_s_q[i]);
                        POS_MIN:  alm_m_d[i] = inc60(alm_m_q[i]);
                        default:  alm_h_d[i] = inc24(alm_h_q[i]);
                    endcase
                end
            end
        end

        // Only tick-driven time changes can match; descending scan leaves the lowest index.
        hit    = 1'b0;
        hit_id = 2'd0;
        for (int i = int'(N_ALARM) - 1; i >= 0; i--) begin
            if (tick && en_q[i] && alm_h_q[i] == hour_d && alm_m_q[i] == min_d &&
                alm_s_q[i] == sec_d) begin
                hit    = 1'b1;
                hit_id = 2'(i);
            end
        end

        ring_chan_en = 1'b0;
        for (int i = 0; i < int'(N_ALARM); i++) begin
            if (2'(i) == ring_id_q) ring_chan_en = en_d[i];
        end
        ring_kill = i_stop || !ring_chan_en || (mode_d == MODE_SETUP);

        ring_d     = ring_q;
        ring_id_d  = ring_id_q;
        ring_cnt_d = ring_cnt_q;
`ifdef SNOOZE_EN
        snz_d      = snz_q;
        snz_cnt_d  = snz_cnt_q;
`endif
        if (ring_q) begin
            if (tick) begin
                if (ring_cnt_q == RING_MAX) ring_d = 1'b0;
                else                        ring_cnt_d = ring_cnt_q + 8'd1;
            end
`ifdef SNOOZE_EN
            if (i_snooze) begin
                ring_d    = 1'b0;
                snz_d     = 1'b1;
                snz_cnt_d = '0;
            end
`endif
            if (ring_kill) begin
                ring_d = 1'b0;
`ifdef SNOOZE_EN
                snz_d  = 1'b0;
`endif
            end
        end else begin
`ifdef SNOOZE_EN
            if (snz_q) begin
                if (ring_kill) begin
                    snz_d = 1'b0;
                end else if (tick) begin
                    if (snz_cnt_q == SNZ_MAX) begin
                        ring_d     = 1'b1;
                        ring_cnt_d = '0;
                        snz_d      = 1'b0;
                    end else begin
                        snz_cnt_d = snz_cnt_q + 16'd1;
                    end
                end
            end
`endif
            // A fresh match pre-empts any pending snooze.
            if (!ring_d && hit && mode_d != MODE_SETUP) begin
                ring_d     = 1'b1;
                ring_id_d  = hit_id;
                ring_cnt_d = '0;
`ifdef SNOOZE_EN
                snz_d      = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            mode_q     <= MODE_CLOCK;
            pos_q      <= POS_SEC;
            sel_q      <= '0;
            en_q       <= '0;
            alm_h_q    <= '{default: '0};
            alm_m_q    <= '{default: '0};
            alm_s_q    <= '{default: '0};
            ring_q     <= 1'b0;
            ring_id_q  <= '0;
            ring_cnt_q <= '0;
`ifdef SNOOZE_EN
            snz_q      <= 1'b0;
            snz_cnt_q  <= '0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            mode_q     <= mode_d;
            pos_q      <= pos_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            alm_h_q    <= alm_h_d;
            alm_m_q    <= alm_m_d;
            alm_s_q    <= alm_s_d;
            ring_q     <= ring_d;
            ring_id_q  <= ring_id_d;
            ring_cnt_q <= ring_cnt_d;
`ifdef SNOOZE_EN
            snz_q      <= snz_d;
            snz_cnt_q  <= snz_cnt_d;
`endif
        end
    end

    always_comb begin
        o_hour = hour_q;
        o_min  = min_q;
        o_sec  = sec_q;
        if (mode_q == MODE_ALARM) begin
            for (int i = 0; i < int'(N_ALARM); i++) begin
                if (2'(i) == sel_q) begin
                    o_hour = alm_h_q[i];
                    o_min  = alm_m_q[i];
                    o_sec  = alm_s_q[i];
                end
            end
        end
    end

    assign o_mode     = mode_q;
    assign o_pos      = pos_q;
    assign o_sel      = sel_q;
    assign o_alarm_en = en_q;
    assign o_ring     = ring_q;
    assign o_ring_id  = ring_id_q;
    assign o_tick     = tick;

endmodule

// File: doc/hms_alarm_core.md
HMS_ALARM_CORE -- requirements
Module: hms_alarm_core

Interface
REQ-001 Parameter CLK_DIV, default 50000000: clk cycles per one-second tick; legal range 2..2^32-1.
REQ-002 Parameter N_ALARM, default 2: number of independent alarm channels; legal range 1..4.
REQ-003 Parameter RING_SEC, default 60: seconds a ring lasts before auto-stop; legal range 1..255.
REQ-004 Parameter SNOOZE_SEC, default 300: snooze delay in seconds; legal range 1..65535.
REQ-005 clk  in  1  the single clock; every register in the block is clocked on posedge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_mode  in  1  debounced one-cycle pulse that advances the mode.
REQ-008 i_pos  in  1  one-cycle pulse that advances the edit field.
REQ-009 i_inc  in  1  one-cycle pulse that increments the selected field.
REQ-010 i_sel  in  1  one-cycle pulse that advances the selected alarm index.
REQ-011 i_tgl  in  1  one-cycle pulse that toggles the enable of the selected alarm.
REQ-012 i_stop  in  1  one-cycle pulse that stops an active ring.
REQ-013 i_snooze  in  1  one-cycle pulse that snoozes an active ring; the port is always present.
REQ-014 o_hour  out  5  displayed hours, 0..23.
REQ-015 o_min  out  6  displayed minutes, 0..59.
REQ-016 o_sec  out  6  displayed seconds, 0..59.
REQ-017 o_mode  out  2  current mode: 0 CLOCK, 1 SETUP, 2 ALARM.
REQ-018 o_pos  out  2  current edit field: 0 SEC, 1 MIN, 2 HOUR.
REQ-019 o_sel  out  2  selected alarm index.
REQ-020 o_alarm_en  out  N_ALARM  per-channel alarm enable bits.
REQ-021 o_ring  out  1  high while the ring is active.
REQ-022 o_ring_id  out  2  index of the ringing channel.
REQ-023 o_tick  out  1  one-cycle pulse for each one-second tick.

Function
REQ-024 Tick counter SHALL count 0..CLK_DIV-1, assert o_tick in the cycle it equals CLK_DIV-1, then wrap to 0.
REQ-025 Time SHALL advance on o_tick: sec 59->0 carries to min, min 59->0 carries to hour, hour 23->0.
REQ-026 The mode FSM SHALL cycle CLOCK->SETUP->ALARM->CLOCK on i_mode; every mode change SHALL set o_pos to SEC.
REQ-027 i_pos SHALL cycle o_pos SEC->MIN->HOUR->SEC in SETUP and ALARM modes; i_pos SHALL be ignored in CLOCK mode.
REQ-028 In SETUP, the tick counter SHALL be held at 0 and o_tick SHALL stay low.
REQ-029 In SETUP, i_inc SHALL increment the selected time field with wrap and without carry.
REQ-030 In SETUP, leaving the mode SHALL restart the tick count from 0.
REQ-031 In ALARM mode, timekeeping SHALL continue.
REQ-032 In ALARM mode, the display SHALL show alarm[o_sel].
REQ-033 In ALARM mode, i_inc SHALL increment the selected field of alarm[o_sel] with wrap.
REQ-034 In ALARM mode, i_sel SHALL cycle o_sel 0..N_ALARM-1.
REQ-035 i_tgl SHALL toggle o_alarm_en[o_sel] in any mode.
REQ-036 If i_mode coincides with i_pos, i_inc or i_sel in the same cycle, i_mode SHALL win and the other pulses SHALL be dropped.
REQ-037 Ring start: in the cycle after time changes to equal an enabled alarm's h:m:s, o_ring SHALL rise and o_ring_id SHALL latch that channel's index.
REQ-038 Simultaneous matches SHALL resolve to the lowest index.
REQ-039 Matches occurring while o_ring is high SHALL be ignored.
REQ-040 Ring SHALL end on i_stop, after RING_SEC ticks, on clearing o_alarm_en[o_ring_id], or in SETUP.
REQ-041 o_ring_id SHALL hold its value after the ring ends.
REQ-042 Editing time in SETUP SHALL NOT trigger a ring.

Reset
REQ-043 While rst_n is low: o_hour, o_min, o_sec, o_mode, o_pos, o_sel, o_alarm_en, o_ring, o_ring_id, o_tick, the tick counter, ring and snooze counters, and all alarm registers SHALL be 0.
REQ-044 Reset asserted mid-ring or mid-snooze SHALL cancel all pending activity; no ring occurs after release until a new match.

Configuration
REQ-045 With SNOOZE_EN defined, i_snooze during a ring SHALL drop o_ring and re-raise it for the same o_ring_id exactly SNOOZE_SEC ticks later.
REQ-046 With SNOOZE_EN defined, i_stop or disabling that channel SHALL cancel a pending snooze, and a further snooze SHALL restart the count.
REQ-047 Without SNOOZE_EN, i_snooze SHALL be ignored and no snooze logic SHALL be synthesised.

Verification
REQ-048 CLK_DIV=4, 23:59:58, CLOCK mode, 8 cycles -> two o_tick pulses, display 00:00:00.
REQ-049 SETUP, pos HOUR, hour 23, i_inc -> hour 0, min/sec unchanged, o_tick silent throughout.
REQ-050 Alarms 0 and 1 both set to 00:00:05 and enabled, run from 0 -> o_ring=1 one cycle after the 5th tick, o_ring_id=0.
REQ-051 RING_SEC=3 ring, no stop -> o_ring falls on the 3rd subsequent tick; i_stop mid-ring -> falls the next cycle.
REQ-052 SNOOZE_EN defined, SNOOZE_SEC=2, i_snooze during ring -> o_ring low, then high again after 2 ticks with the same id; undefined -> ignored.
REQ-053 rst_n pulsed low during ring -> all outputs 0 immediately; no ring afterwards until a new match.
